mcycle_unit: RTL and testbench
==============================

MCYCLE_UNIT -- requirements
Module: mcycle_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 SHALL provide port CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL provide port RESETn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port Start  input  1  request from the control unit to begin an operation.
REQ-005 SHALL provide port MCycleOp  input  2  operation select: bit0 0=multiply, 1=divide; bit1 0=unsigned, 1=signed.
REQ-006 SHALL provide port Operand1  input  WIDTH  multiplicand or dividend.
REQ-007 SHALL provide port Operand2  input  WIDTH  multiplier or divisor.
REQ-008 SHALL provide port Result1  output  WIDTH  product low half, or quotient.
REQ-009 SHALL provide port Result2  output  WIDTH  product high half, or remainder.
REQ-010 SHALL provide port Busy  output  1  high while an operation is in progress; the control unit stalls on it.
REQ-011 SHALL provide port Done  output  1  one-cycle pulse in the cycle in which new results are first valid.

Function
REQ-012 SHALL implement the states IDLE, COMPUTE and DONE.
REQ-013 In IDLE or DONE, Start=1 at a rising edge SHALL perform these actions:
- latch MCycleOp;
- latch the operand magnitudes and signs (magnitude = two's-complement absolute value when bit1=1);
- clear the iteration counter;
- enter COMPUTE.
REQ-014 Busy SHALL be 1 in exactly the 32 cycles following the accepting edge, for WIDTH=32 (WIDTH cycles in general).
REQ-015 Each COMPUTE cycle SHALL perform one iteration and increment a counter of $clog2(WIDTH)+1 bits.
- Multiply: shift-add of one multiplier bit into a 2*WIDTH accumulator.
- Divide: restoring divide; shift the remainder left by one, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
REQ-016 The edge that completes iteration WIDTH SHALL write Result1/Result2, enter DONE, and drop Busy.
- Done SHALL be 1 for the following single cycle.
REQ-017 Multiply results SHALL be Result1 = product[WIDTH-1:0] and Result2 = product[2*WIDTH-1:WIDTH].
- If signed and the operand signs differ, the full 2*WIDTH product SHALL be negated.
REQ-018 Divide results SHALL be Result1 = quotient and Result2 = remainder.
- Signed division SHALL truncate toward zero.
- The quotient SHALL be negated when the operand signs differ.
- The remainder SHALL take the sign of the dividend.
REQ-019 Divisor zero (either signedness) SHALL still take the full WIDTH cycles, then give Result1 = all ones and Result2 = Operand1 as latched.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give Result1 = 0x80000000 and Result2 = 0.
REQ-021 Start while Busy=1 SHALL be ignored, and changes to Operand1/Operand2/MCycleOp during COMPUTE SHALL have no effect.
REQ-022 Start=1 in the DONE cycle SHALL be accepted, giving back-to-back operations with Busy low for that one cycle only.
REQ-023 Result1/Result2 SHALL hold their values from completion until the next completion.
- During COMPUTE they SHALL keep the previous results and never show partial values.
REQ-024 In DONE with Start=0, the next state SHALL be IDLE.

Reset
REQ-025 RESETn=0 SHALL immediately, without waiting for a clock edge, force the following:
- state IDLE;
- Busy=0 and Done=0;
- Result1=0 and Result2=0;
- counter, accumulators and latched operands cleared.
REQ-026 Reset asserted mid-operation SHALL abandon the operation without producing results.
- After RESETn returns high, the first Start SHALL be accepted normally.
REQ-027 Start SHALL be ignored while RESETn=0.

Verification
REQ-028 Unsigned multiply 0xFFFFFFFF * 0xFFFFFFFF -> Busy high for exactly 32 cycles, then Result1=0x00000001, Result2=0xFFFFFFFE, Done pulses once.
REQ-029 Signed multiply 0xFFFFFFFD (-3) * 0x00000005 -> Result1=0xFFFFFFF1, Result2=0xFFFFFFFF.
REQ-030 Divide, two operations back-to-back, with Start held high through DONE:
- unsigned 100 / 7 -> Result1=14, Result2=2;
- signed 0xFFFFFFF9 (-7) / 2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF;
- Busy low for exactly one cycle between the two operations.
REQ-031 Unsigned 0x12345678 / 0 -> after 32 cycles, Result1=0xFFFFFFFF and Result2=0x12345678.
REQ-032 Start pulses and operand changes during COMPUTE -> ignored; results correspond to the originally latched operands.
REQ-033 RESETn pulsed low at COMPUTE cycle 10 -> Busy=0 and Result1=Result2=0 immediately; no Done pulse; a following 6*7 multiply -> Result1=42.

Source files
------------

// File: rtl/mcycle_unit.sv
// Multi-cycle iterative multiply/divide unit, unsigned or signed, one result bit-step per cycle.
// Latency: WIDTH cycles from the accepting edge to results; Done pulses in the following cycle.
// Backpressure: Busy is held high while computing; Start is ignored until the unit is back in IDLE or DONE.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         op;
    logic               sign1;
    logic               sign2;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [CW-1:0]      count;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   op1_abs;
    logic [WIDTH-1:0]   op2_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] prod;
    logic               neg;
    logic [WIDTH-1:0]   res1;
    logic [WIDTH-1:0]   res2;
    logic               last;

    // Operand magnitudes at the point of acceptance; only negate when the op is signed.
    always_comb begin
        op1_abs = Operand1;
        op2_abs = Operand2;
        if (MCycleOp[1] && Operand1[WIDTH-1]) op1_abs = -Operand1;
        if (MCycleOp[1] && Operand2[WIDTH-1]) op2_abs = -Operand2;
    end

    // One iteration of shift-add multiply or restoring divide, plus final sign fix-up.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag1} : '0);
        div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_sh - {1'b0, mag2};
        acc_nxt  = {mul_sum, acc[WIDTH-1:1]};
        if (op[0]) begin
            // Bit WIDTH of the trial difference set means the subtraction went negative: restore.
            if (!div_diff[WIDTH]) acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                  acc_nxt = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
        neg  = sign1 ^ sign2;
        prod = neg ? -acc_nxt : acc_nxt;
        res1 = prod[WIDTH-1:0];
        res2 = prod[2*WIDTH-1:WIDTH];
        if (op[0]) begin
            // Zero divisor yields all-ones quotient regardless of sign; the remainder path
            // already reproduces the original dividend once its sign is restored.
            if (mag2 == '0)  res1 = '1;
            else if (neg)    res1 = -acc_nxt[WIDTH-1:0];
            else             res1 = acc_nxt[WIDTH-1:0];
            res2 = sign1 ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
        end
        last = (count == CW'(WIDTH - 1));
    end

    // Control FSM with registered Busy/Done and result registers that only update on completion.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state   <= IDLE;
            op      <= '0;
            sign1   <= 1'b0;
            sign2   <= 1'b0;
            mag1    <= '0;
            mag2    <= '0;
            count   <= '0;
            acc     <= '0;
            Result1 <= '0;
            Result2 <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            case (state)
                COMPUTE: begin
                    acc   <= acc_nxt;
                    count <= count + CW'(1);
                    if (last) begin
                        Result1 <= res1;
                        Result2 <= res2;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    Done <= 1'b0;
                    if (Start) begin
                        op    <= MCycleOp;
                        sign1 <= MCycleOp[1] & Operand1[WIDTH-1];
                        sign2 <= MCycleOp[1] & Operand2[WIDTH-1];
                        mag1  <= op1_abs;
                        mag2  <= op2_abs;
                        acc   <= MCycleOp[0] ? {{WIDTH{1'b0}}, op1_abs} : {{WIDTH{1'b0}}, op2_abs};
                        count <= '0;
                        Busy  <= 1'b1;
                        state <= COMPUTE;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed bench for mcycle_unit: hand-computed multiply/divide results, Busy timing, Done pulse.
// Latency is measured from the accepting edge until Busy falls.
// Back-to-back starts, ignored starts during compute and mid-operation reset are exercised.
module tb_mcycle_unit;

    logic        CLK;
    logic        RESETn;
    logic        Start;
    logic [1:0]  MCycleOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic        Busy;
    logic        Done;

    int          n_cmp;
    int          n_bad;
    logic [31:0] prev_r1;

    mcycle_unit #(.WIDTH(32)) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after the accepting edge; returns number of cycles Busy stayed high.
    // Checks that results hold the previous value mid-compute, optionally disturbs inputs.
    task automatic wait_busy(input string tag, input bit disturb, output int n);
        n = 0;
        while (Busy && n < 100) begin
            if (n == 16) check({tag, "_hold"}, Result1, prev_r1);
            if (disturb && n == 5) begin
                Start    = 1'b1;
                MCycleOp = 2'b11;
                Operand1 = 32'hDEADBEEF;
                Operand2 = 32'h00000007;
            end
            if (disturb && n == 6) Start = 1'b0;
            n++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e1, input logic [31:0] e2,
                         input bit disturb);
        int n;
        @(posedge CLK); #1;
        Start    = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        @(posedge CLK); #1;
        Start = 1'b0;
        wait_busy(tag, disturb, n);
        check({tag, "_cycles"}, 32'(n), 32'd32);
        check({tag, "_done"}, {31'd0, Done}, 32'd1);
        check({tag, "_r1"}, Result1, e1);
        check({tag, "_r2"}, Result2, e2);
        prev_r1 = e1;
        @(posedge CLK); #1;
        check({tag, "_done_off"}, {31'd0, Done}, 32'd0);
    endtask

    initial begin
        int n;
        int done_seen;
        n_cmp    = 0;
        n_bad    = 0;
        prev_r1  = 32'd0;
        RESETn   = 1'b0;
        Start    = 1'b0;
        MCycleOp = 2'b00;
        Operand1 = 32'd0;
        Operand2 = 32'd0;

        #12;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_r1", Result1, 32'd0);
        check("rst_r2", Result2, 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;

        do_op("umul_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0);
        do_op("smul_neg", 2'b10, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0);

        // Back-to-back divides with Start held through DONE.
        @(posedge CLK); #1;
        Start    = 1'b1;
        MCycleOp = 2'b01;
        Operand1 = 32'd100;
        Operand2 = 32'd7;
        @(posedge CLK); #1;
        wait_busy("b2b_a", 1'b0, n);
        check("b2b_a_cycles", 32'(n), 32'd32);
        check("b2b_a_done", {31'd0, Done}, 32'd1);
        check("b2b_a_r1", Result1, 32'd14);
        check("b2b_a_r2", Result2, 32'd2);
        prev_r1  = 32'd14;
        MCycleOp = 2'b11;
        Operand1 = 32'hFFFFFFF9;
        Operand2 = 32'd2;
        @(posedge CLK); #1;
        check("b2b_rebusy", {31'd0, Busy}, 32'd1);
        check("b2b_done_off", {31'd0, Done}, 32'd0);
        Start = 1'b0;
        wait_busy("b2b_b", 1'b0, n);
        check("b2b_b_cycles", 32'(n), 32'd32);
        check("b2b_b_done", {31'd0, Done}, 32'd1);
        check("b2b_b_r1", Result1, 32'hFFFFFFFD);
        check("b2b_b_r2", Result2, 32'hFFFFFFFF);
        prev_r1 = 32'hFFFFFFFD;
        @(posedge CLK); #1;
        check("b2b_b_done_off", {31'd0, Done}, 32'd0);

        do_op("udiv_zero", 2'b01, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, 1'b0);
        do_op("sdiv_zero", 2'b11, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0);
        do_op("sdiv_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0);
        do_op("sdiv_mix", 2'b11, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0);
        do_op("ignore", 2'b00, 32'h00012345, 32'h00010000, 32'h23450000, 32'h00000001, 1'b1);

        // Reset during compute: abandon, clear outputs, ignore Start while held.
        @(posedge CLK); #1;
        Start    = 1'b1;
        MCycleOp = 2'b00;
        Operand1 = 32'h00001000;
        Operand2 = 32'd5;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (10) begin
            @(posedge CLK); #1;
        end
        RESETn = 1'b0;
        #1;
        check("arst_busy", {31'd0, Busy}, 32'd0);
        check("arst_done", {31'd0, Done}, 32'd0);
        check("arst_r1", Result1, 32'd0);
        check("arst_r2", Result2, 32'd0);
        Start    = 1'b1;
        Operand1 = 32'd9;
        Operand2 = 32'd9;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("arst_start_ign", {31'd0, Busy}, 32'd0);
        Start  = 1'b0;
        RESETn = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (Done || Busy) done_seen++;
        end
        check("arst_no_done", 32'(done_seen), 32'd0);
        prev_r1 = 32'd0;
        do_op("post_rst", 2'b00, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
